rv32i_reorder_buffer: RTL and testbench

RV32I_REORDER_BUFFER -- requirements
Module: rv32i_reorder_buffer

---
 rtl/rv32i_pkg.sv | 17 +
 rtl/rv32i_reorder_buffer.sv | 112 +++++++++++
 tb/tb_rv32i_reorder_buffer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I core types: register-file index widths and the reorder buffer entry layout.
package rv32i_pkg;

  localparam int ROB_DEPTH_DEFAULT    = 16;
  localparam int ROB_IDX_BW           = $clog2(ROB_DEPTH_DEFAULT);
  localparam int ARCH_REG_FILE_IDX_BW = 5;
  localparam int PHYS_REG_FILE_IDX_BW = 6;

  typedef struct packed {
    logic                            vld;
    logic                            done;
    logic                            dst_vld;
    logic [ARCH_REG_FILE_IDX_BW-1:0] arch_idx;
    logic [PHYS_REG_FILE_IDX_BW-1:0] phys_idx;
  } rob_entry_t;

endpackage

// File: rtl/rv32i_reorder_buffer.sv
// In-order retire reorder buffer: circular entry array with wrap-bit pointers,
// out-of-order completion marking, and one registered retire per cycle.
module rv32i_reorder_buffer
  import rv32i_pkg::*;
#(
  parameter  int ROB_DEPTH = ROB_DEPTH_DEFAULT,
  localparam int IDX_BW    = $clog2(ROB_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            i_alloc_vld,
  input  logic                            i_alloc_dst_vld,
  input  logic [ARCH_REG_FILE_IDX_BW-1:0] i_alloc_arch_rf_idx,
  input  logic [PHYS_REG_FILE_IDX_BW-1:0] i_alloc_phys_rf_idx,
  output logic                            o_alloc_rdy,
  output logic [IDX_BW-1:0]               o_alloc_rob_idx,
  input  logic                            i_cmpl_vld,
  input  logic [IDX_BW-1:0]               i_cmpl_rob_idx,
  output logic                            o_retire,
  output logic                            o_retire_dst_vld,
  output logic [ARCH_REG_FILE_IDX_BW-1:0] o_retire_arch_rf_idx,
  output logic [PHYS_REG_FILE_IDX_BW-1:0] o_retire_phys_rf_idx,
  output logic [IDX_BW:0]                 o_rob_cnt,
  output logic                            o_rob_empty
);

  localparam logic [IDX_BW:0] PTR_ONE = (IDX_BW+1)'(1);

  rob_entry_t rob_q [ROB_DEPTH];
  rob_entry_t rob_d [ROB_DEPTH];

  logic [IDX_BW:0] head_q, head_d, tail_q, tail_d;
  logic [IDX_BW-1:0] head_idx, tail_idx;
  logic full, empty, alloc_fire, ret_fire;
  rob_entry_t head_ent;

  logic                            ret_q;
  logic                            ret_dst_q;
  logic [ARCH_REG_FILE_IDX_BW-1:0] ret_arch_q;
  logic [PHYS_REG_FILE_IDX_BW-1:0] ret_phys_q;

  assign head_idx   = head_q[IDX_BW-1:0];
  assign tail_idx   = tail_q[IDX_BW-1:0];
  assign empty      = (head_q == tail_q);
  assign full       = (head_idx == tail_idx) && (head_q[IDX_BW] != tail_q[IDX_BW]);
  assign head_ent   = rob_q[head_idx];
  // Both decisions come from registered state only; a retire never frees a slot for the same edge.
  assign ret_fire   = head_ent.vld & head_ent.done;
  assign alloc_fire = i_alloc_vld & ~full;

  always_comb begin
    rob_d  = rob_q;
    head_d = head_q;
    tail_d = tail_q;
    if (i_cmpl_vld && rob_q[i_cmpl_rob_idx].vld)
      rob_d[i_cmpl_rob_idx].done = 1'b1;
    if (ret_fire) begin
      rob_d[head_idx].vld = 1'b0;
      head_d              = head_q + PTR_ONE;
    end
    if (alloc_fire) begin
      rob_d[tail_idx].vld      = 1'b1;
      rob_d[tail_idx].done     = 1'b0;
      rob_d[tail_idx].dst_vld  = i_alloc_dst_vld;
      rob_d[tail_idx].arch_idx = i_alloc_arch_rf_idx;
      rob_d[tail_idx].phys_idx = i_alloc_phys_rf_idx;
      tail_d                   = tail_q + PTR_ONE;
    end
  end

  // Payload fields are intentionally left out of reset; only the status bits clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rob_q[i].vld  <= 1'b0;
        rob_q[i].done <= 1'b0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      rob_q  <= rob_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ret_q      <= 1'b0;
      ret_dst_q  <= 1'b0;
      ret_arch_q <= '0;
      ret_phys_q <= '0;
    end else begin
      ret_q <= ret_fire;
      if (ret_fire) begin
        ret_dst_q  <= head_ent.dst_vld;
        ret_arch_q <= head_ent.arch_idx;
        ret_phys_q <= head_ent.phys_idx;
      end
    end
  end

  assign o_alloc_rdy          = ~full;
  assign o_alloc_rob_idx      = tail_idx;
  assign o_retire             = ret_q;
  assign o_retire_dst_vld     = ret_dst_q;
  assign o_retire_arch_rf_idx = ret_arch_q;
  assign o_retire_phys_rf_idx = ret_phys_q;
  assign o_rob_cnt            = tail_q - head_q;
  assign o_rob_empty          = empty;

endmodule

// File: tb/tb_rv32i_reorder_buffer.sv
// Bench for rv32i_reorder_buffer: queue-based reference model, a vector table,
// directed corner sequences and randomized traffic.
module tb_rv32i_reorder_buffer;

  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       i_alloc_vld = 1'b0, i_alloc_dst_vld = 1'b0;
  logic [4:0] i_alloc_arch_rf_idx = '0;
  logic [5:0] i_alloc_phys_rf_idx = '0;
  logic       o_alloc_rdy;
  logic [3:0] o_alloc_rob_idx;
  logic       i_cmpl_vld = 1'b0;
  logic [3:0] i_cmpl_rob_idx = '0;
  logic       o_retire, o_retire_dst_vld;
  logic [4:0] o_retire_arch_rf_idx;
  logic [5:0] o_retire_phys_rf_idx;
  logic [4:0] o_rob_cnt;
  logic       o_rob_empty;

  always #5 clk = ~clk;

  rv32i_reorder_buffer #(.ROB_DEPTH(D)) dut (
    .clk(clk), .rstn(rstn),
    .i_alloc_vld(i_alloc_vld), .i_alloc_dst_vld(i_alloc_dst_vld),
    .i_alloc_arch_rf_idx(i_alloc_arch_rf_idx), .i_alloc_phys_rf_idx(i_alloc_phys_rf_idx),
    .o_alloc_rdy(o_alloc_rdy), .o_alloc_rob_idx(o_alloc_rob_idx),
    .i_cmpl_vld(i_cmpl_vld), .i_cmpl_rob_idx(i_cmpl_rob_idx),
    .o_retire(o_retire), .o_retire_dst_vld(o_retire_dst_vld),
    .o_retire_arch_rf_idx(o_retire_arch_rf_idx), .o_retire_phys_rf_idx(o_retire_phys_rf_idx),
    .o_rob_cnt(o_rob_cnt), .o_rob_empty(o_rob_empty)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: program-order queue of in-flight entries plus a done flag per slot.
  typedef struct {
    int idx; bit dst; int arch; int phys;
  } ent_t;
  ent_t      mq[$];
  bit [D-1:0] mdone;
  int        alloc_total;
  bit        m_ret, m_dst;
  int        m_arch, m_phys;

  function automatic bit in_flight(input int idx);
    foreach (mq[i]) if (mq[i].idx == idx) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    mq.delete();
    mdone = '0;
    alloc_total = 0;
    m_ret = 0; m_dst = 0; m_arch = 0; m_phys = 0;
  endtask

  // Called just after a negedge; leaves the bench just after the following negedge.
  task automatic cycle(input bit a, input int ar, input int ph, input bit c, input int ci);
    bit erdy, fire, dor;
    int eidx;
    ent_t e;
    i_alloc_vld = a;
    i_alloc_dst_vld = (ar != 0);
    i_alloc_arch_rf_idx = 5'(ar);
    i_alloc_phys_rf_idx = 6'(ph);
    i_cmpl_vld = c;
    i_cmpl_rob_idx = 4'(ci);
    #1;
    erdy = (mq.size() < D);
    eidx = alloc_total % D;
    chk("alloc_rdy", o_alloc_rdy, erdy);
    chk("alloc_idx", o_alloc_rob_idx, eidx);
    fire = a && erdy;
    dor  = (mq.size() > 0) && mdone[mq[0].idx];
    if (c && in_flight(ci)) mdone[ci] = 1'b1;
    m_ret = dor;
    if (dor) begin
      e = mq.pop_front();
      m_dst = e.dst; m_arch = e.arch; m_phys = e.phys;
    end
    if (fire) begin
      e.idx = eidx; e.dst = (ar != 0); e.arch = ar; e.phys = ph;
      mq.push_back(e);
      mdone[eidx] = 1'b0;
      alloc_total++;
    end
    @(posedge clk);
    #1;
    chk("retire", o_retire, m_ret);
    chk("ret_dst", o_retire_dst_vld, m_dst);
    chk("ret_arch", o_retire_arch_rf_idx, m_arch);
    chk("ret_phys", o_retire_phys_rf_idx, m_phys);
    chk("rob_cnt", o_rob_cnt, mq.size());
    chk("rob_empty", o_rob_empty, mq.size() == 0);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0);
  endtask

  // Asserts reset between edges and checks that outputs clear without waiting for a clock.
  task automatic do_reset();
    i_alloc_vld = 0; i_cmpl_vld = 0;
    #2 rstn = 1'b0;
    #1;
    chk("rst_retire", o_retire, 0);
    chk("rst_phys", o_retire_phys_rf_idx, 0);
    chk("rst_arch", o_retire_arch_rf_idx, 0);
    chk("rst_cnt", o_rob_cnt, 0);
    chk("rst_empty", o_rob_empty, 1);
    chk("rst_rdy", o_alloc_rdy, 1);
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  typedef struct {
    bit a; int ar; int ph; bit c; int ci;
    bit e_ret; int e_phys; int e_cnt;
  } vec_t;
  vec_t vec[8];

  initial begin
    int ci;
    bit a, c;
    vec[0] = '{1, 1, 33, 0, 0, 0, 0, 1};
    vec[1] = '{1, 2, 34, 0, 0, 0, 0, 2};
    vec[2] = '{1, 3, 35, 0, 0, 0, 0, 3};
    vec[3] = '{0, 0, 0, 1, 0, 0, 0, 3};
    vec[4] = '{0, 0, 0, 1, 1, 1, 33, 2};
    vec[5] = '{0, 0, 0, 1, 2, 1, 34, 1};
    vec[6] = '{0, 0, 0, 0, 0, 1, 35, 0};
    vec[7] = '{0, 0, 0, 0, 0, 0, 35, 0};

    model_clear();
    @(negedge clk); @(negedge clk);
    chk("init_retire", o_retire, 0);
    chk("init_cnt", o_rob_cnt, 0);
    chk("init_empty", o_rob_empty, 1);
    chk("init_rdy", o_alloc_rdy, 1);
    rstn = 1'b1;

    // in-order completion, three back-to-back retires
    foreach (vec[i]) begin
      cycle(vec[i].a, vec[i].ar, vec[i].ph, vec[i].c, vec[i].ci);
      chk("tbl_retire", o_retire, vec[i].e_ret);
      chk("tbl_phys", o_retire_phys_rf_idx, vec[i].e_phys);
      chk("tbl_cnt", o_rob_cnt, vec[i].e_cnt);
    end

    // younger completes first; nothing retires until the head is done
    do_reset();
    cycle(1, 5, 40, 0, 0);
    cycle(1, 6, 41, 0, 0);
    cycle(0, 0, 0, 1, 1); chk("ooo_hold0", o_retire, 0);
    idle();               chk("ooo_hold1", o_retire, 0);
    idle();               chk("ooo_hold2", o_retire, 0);
    cycle(0, 0, 0, 1, 0); chk("ooo_hold3", o_retire, 0);
    idle(); chk("ooo_r0", o_retire, 1); chk("ooo_r0_phys", o_retire_phys_rf_idx, 40);
    idle(); chk("ooo_r1", o_retire, 1); chk("ooo_r1_phys", o_retire_phys_rf_idx, 41);
    idle(); chk("ooo_r2", o_retire, 0);

    // fill to full, then overflow attempt, then retire-frees-slot with alloc held
    do_reset();
    for (int k = 0; k < D; k++) cycle(1, (k % 31) + 1, k, 0, 0);
    chk("full_rdy", o_alloc_rdy, 0);
    chk("full_cnt", o_rob_cnt, D);
    cycle(1, 7, 50, 0, 0);
    chk("ovf_idx", o_alloc_rob_idx, 0);
    chk("ovf_cnt", o_rob_cnt, D);
    cycle(1, 8, 51, 1, 0);
    chk("full_hold_rdy", o_alloc_rdy, 0);
    cycle(1, 8, 51, 0, 0);
    chk("free_ret", o_retire, 1);
    chk("free_rdy", o_alloc_rdy, 1);
    chk("free_idx", o_alloc_rob_idx, 0);
    cycle(1, 8, 51, 0, 0);
    chk("wrap_cnt", o_rob_cnt, D);
    chk("wrap_rdy", o_alloc_rdy, 0);

    // steady occupancy of 5 across several pointer wraps
    do_reset();
    for (int k = 0; k < 45; k++) begin
      cycle(1, (k % 31) + 1, k % 64, k >= 4, (k >= 4) ? (k - 4) % D : 0);
      if (k >= 4) chk("steady_cnt", o_rob_cnt, 5);
      if (k >= 5) chk("steady_phys", o_retire_phys_rf_idx, (k - 5) % 64);
    end

    // async reset with entries in flight and a retire pulse on the outputs
    do_reset();
    for (int k = 0; k < 6; k++) cycle(1, k + 10, k + 20, 0, 0);
    cycle(0, 0, 0, 1, 0);
    idle();
    chk("pre_rst_ret", o_retire, 1);
    do_reset();
    idle();
    chk("post_rst_empty", o_rob_empty, 1);
    chk("post_rst_cnt", o_rob_cnt, 0);

    // randomized traffic against the model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      a = ($urandom_range(0, 99) < 60);
      c = ($urandom_range(0, 99) < 55);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        ci = mq[$urandom_range(0, mq.size() - 1)].idx;
      else
        ci = $urandom_range(0, D - 1);
      if (a && mq.size() < D && ci == alloc_total % D) c = 0;
      cycle(a, $urandom_range(0, 31), $urandom_range(0, 63), c, ci);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
